// File: rtl/ultrasonido_pkg.sv
// Shared timing defaults, field widths and FSM state codes for the HC-SR04 range controller.
// Defaults assume a 50 MHz clock: 10 us trigger, 58 us of echo per centimetre, 30 ms echo wait.
package ultrasonido_pkg;

   localparam int CLK_MHZ    = 50;
   localparam int TRIG_US    = 10;
   localparam int US_PER_CM  = 58;
   localparam int TIMEOUT_US = 30000;

   localparam int DEF_TRIG_CYCLES   = CLK_MHZ * TRIG_US;
   localparam int DEF_CYCLES_PER_CM = CLK_MHZ * US_PER_CM;
   localparam int DEF_THRESHOLD_CM  = 10;
   localparam int DEF_MAX_CM        = 400;
   localparam int DEF_ECHO_TIMEOUT  = CLK_MHZ * TIMEOUT_US;

   localparam int CM_W  = 9;
   localparam int PRE_W = 12;
   localparam int CNT_W = 21;

   localparam logic [2:0] IDLE      = 3'd0;
   localparam logic [2:0] TRIG      = 3'd1;
   localparam logic [2:0] WAIT_ECHO = 3'd2;
   localparam logic [2:0] MEASURE   = 3'd3;
   localparam logic [2:0] DONE      = 3'd4;

   typedef logic [CM_W-1:0] cm_t;

   function automatic cm_t cm_sat_inc(input cm_t cm, input cm_t max_cm);
      return (cm == max_cm) ? cm : cm + cm_t'(1);
   endfunction

endpackage

// File: rtl/ultrasonido_ctrl_sync2.sv
// Two-flop synchroniser for the asynchronous echo pin.
// Latency: 2 clocks; no flow control.
module ultrasonido_ctrl_sync2
   import ultrasonido_pkg::*;
(
   input  logic clk,
   input  logic rst,
   input  logic d,
   output logic q
);

   logic meta;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         meta <= 1'b0;
         q    <= 1'b0;
      end else begin
         meta <= d;
         q    <= meta;
      end
   end

endmodule

// File: rtl/ultrasonido_ctrl.sv
// Ultrasonic ranger: trigger pulse, echo width timing, cm conversion, proximity led; ULTRASONIDO_DIST_OUT_EN adds distance_cm/dist_valid.
// Latency: led settles 2 clocks after the synchronised echo falls (echo pin adds 2 more).
// Backpressure: none; boton is a level request, ignored while a measurement is in flight.
module ultrasonido_ctrl
   import ultrasonido_pkg::*;
#(
   parameter int TRIG_CYCLES   = DEF_TRIG_CYCLES,
   parameter int CYCLES_PER_CM = DEF_CYCLES_PER_CM,
   parameter int THRESHOLD_CM  = DEF_THRESHOLD_CM,
   parameter int MAX_CM        = DEF_MAX_CM,
   parameter int ECHO_TIMEOUT  = DEF_ECHO_TIMEOUT
) (
   input  logic            clk,
   input  logic            reset_n,
   input  logic            echo,
   input  logic            boton,
   output logic            led,
`ifdef ULTRASONIDO_DIST_OUT_EN
   output logic [CM_W-1:0] distance_cm,
   output logic            dist_valid,
`endif
   output logic            trigger
);

   localparam logic [CNT_W-1:0] TRIG_LAST    = CNT_W'(TRIG_CYCLES - 1);
   localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(ECHO_TIMEOUT - 1);
   localparam logic [PRE_W-1:0] PRE_LAST     = PRE_W'(CYCLES_PER_CM - 1);
   localparam logic [CM_W-1:0]  CM_MAX       = CM_W'(MAX_CM);
   localparam logic [CM_W-1:0]  CM_THRESH    = CM_W'(THRESHOLD_CM);

   logic [2:0]       state;
   logic [CNT_W-1:0] cnt;
   logic [PRE_W-1:0] pre;
   logic [CM_W-1:0]  cm;
   logic             echo_s;

   ultrasonido_ctrl_sync2 u_echo_sync (
      .clk (clk),
      .rst (reset_n),
      .d   (echo),
      .q   (echo_s)
   );

   always_ff @(posedge clk or posedge reset_n) begin
      if (reset_n) begin
         state   <= IDLE;
         trigger <= 1'b0;
         led     <= 1'b0;
         cnt     <= '0;
         pre     <= '0;
         cm      <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (boton) begin
                  cnt     <= '0;
                  pre     <= '0;
                  cm      <= '0;
                  trigger <= 1'b1;
                  state   <= TRIG;
               end
            end
            TRIG: begin
               if (cnt == TRIG_LAST) begin
                  cnt     <= '0;
                  trigger <= 1'b0;
                  state   <= WAIT_ECHO;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            WAIT_ECHO: begin
               if (echo_s) begin
                  cm    <= '0;
                  pre   <= '0;
                  state <= MEASURE;
               end else if (cnt == TIMEOUT_LAST) begin
                  led   <= 1'b0;
                  state <= IDLE;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            MEASURE: begin
               // The high sample that left WAIT_ECHO is never seen here, so a prescaler
               // parked at its last value on the falling sample still closes one full cm.
               if (pre == PRE_LAST) begin
                  cm <= cm_sat_inc(cm, CM_MAX);
               end
               if (echo_s) begin
                  pre <= (pre == PRE_LAST) ? '0 : pre + 1'b1;
               end else begin
                  state <= DONE;
               end
            end
            DONE: begin
               led   <= (cm < CM_THRESH);
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

`ifdef ULTRASONIDO_DIST_OUT_EN
   // dist_valid qualifies the freshly latched value, so it lines up with the led update.
   always_ff @(posedge clk or posedge reset_n) begin
      if (reset_n) begin
         distance_cm <= '0;
         dist_valid  <= 1'b0;
      end else begin
         dist_valid <= (state == DONE);
         if (state == DONE) begin
            distance_cm <= cm;
         end
      end
   end
`endif

endmodule

// File: tb/tb_ultrasonido_ctrl.sv
// Randomised bench for ultrasonido_ctrl with scaled timing parameters and a cycle-level reference schedule.
module tb_ultrasonido_ctrl;

   localparam int TRIG = 20;
   localparam int CPC  = 29;
   localparam int THR  = 10;
   localparam int MAXC = 40;
   localparam int TO   = 3000;

   logic clk;
   logic reset_n;
   logic echo;
   logic boton;
   logic led;
   logic trigger;
`ifdef ULTRASONIDO_DIST_OUT_EN
   logic [8:0] distance_cm;
   logic       dist_valid;
`endif

   ultrasonido_ctrl #(
      .TRIG_CYCLES   (TRIG),
      .CYCLES_PER_CM (CPC),
      .THRESHOLD_CM  (THR),
      .MAX_CM        (MAXC),
      .ECHO_TIMEOUT  (TO)
   ) dut (
      .clk         (clk),
      .reset_n     (reset_n),
      .echo        (echo),
      .boton       (boton),
      .led         (led),
`ifdef ULTRASONIDO_DIST_OUT_EN
      .distance_cm (distance_cm),
      .dist_valid  (dist_valid),
`endif
      .trigger     (trigger)
   );

   initial clk = 1'b0;
   always #10 clk = ~clk;

   // Reference schedule: trigger window and led value as a function of the posedge count.
   int cyc      = 0;
   int trig_lo  = 1;
   int trig_hi  = 0;
   bit led_old  = 1'b0;
   bit led_new  = 1'b0;
   int led_at   = 0;
   int hi_run   = 0;
   bit skip_len = 1'b0;
   int total    = 0;
   int bad      = 0;

   task automatic check(input string name, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s at cycle %0d: got %0d want %0d", name, cyc, act, exp);
      end
   endtask

   task automatic wait_cyc(input int t);
      while (cyc < t) @(negedge clk);
   endtask

   function automatic bit led_for(input int high_cycles);
      int cm;
      cm = high_cycles / CPC;
      if (cm > MAXC) cm = MAXC;
      return cm < THR;
   endfunction

   initial begin
      forever begin
         @(posedge clk);
         cyc++;
         #1;
         check("trigger", int'(trigger), (cyc >= trig_lo && cyc <= trig_hi) ? 1 : 0);
         check("led", int'(led), int'((cyc >= led_at) ? led_new : led_old));
         if (trigger) begin
            hi_run++;
         end else if (hi_run > 0) begin
            if (!skip_len) check("trig_width", hi_run, TRIG);
            hi_run   = 0;
            skip_len = 1'b0;
         end
      end
   end

   // Called on a negedge with the DUT idle (or about to re-enter IDLE with boton held).
   // Echo is raised d cycles after the trigger ends; d < -2 loses echo time spent in TRIG.
   task automatic measure(input int n, input int d, input bit keep);
      int k, w, j, f, lost;
      k       = cyc;
      boton   = 1'b1;
      led_old = led_new;
      trig_lo = k + 1;
      trig_hi = k + TRIG;
      wait_cyc(k + 1);
      boton = keep;
      w     = k + TRIG + 1;
      j     = w + d;
      wait_cyc(j);
      echo    = 1'b1;
      f       = j + n;
      lost    = (d < -2) ? (-2 - d) : 0;
      led_new = led_for(n - lost);
      led_at  = f + 4;
      wait_cyc(f);
      echo = 1'b0;
      wait_cyc(f + 4);
   endtask

   task automatic no_echo();
      int k, w;
      k       = cyc;
      boton   = 1'b1;
      led_old = led_new;
      trig_lo = k + 1;
      trig_hi = k + TRIG;
      wait_cyc(k + 1);
      boton   = 1'b0;
      w       = k + TRIG + 1;
      led_new = 1'b0;
      led_at  = w + TO;
      wait_cyc(w + TO);
   endtask

   task automatic reset_mid();
      int k;
      k       = cyc;
      boton   = 1'b1;
      led_old = led_new;
      trig_lo = k + 1;
      trig_hi = k + TRIG;
      wait_cyc(k + 1);
      boton = 1'b0;
      wait_cyc(k + 8);
      #2;
      reset_n  = 1'b1;
      trig_lo  = 1;
      trig_hi  = 0;
      led_old  = 1'b0;
      led_new  = 1'b0;
      led_at   = 0;
      skip_len = 1'b1;
      #1;
      check("mid_reset_trigger", int'(trigger), 0);
      check("mid_reset_led", int'(led), 0);
      #9;
      reset_n = 1'b0;
      @(negedge clk);
   endtask

   initial begin
      bit keep;
      reset_n = 1'b0;
      boton   = 1'b0;
      echo    = 1'b0;
      #1 reset_n = 1'b1;
      @(negedge clk);
      check("reset_trigger", int'(trigger), 0);
      check("reset_led", int'(led), 0);
      @(negedge clk);
      #2 reset_n = 1'b0;
      @(negedge clk);

      measure(20, 0, 1'b0);
      check("short_echo_led", int'(led), 1);
      measure(9 * CPC, 3, 1'b0);
      check("nine_cm_led", int'(led), 1);
      measure(10 * CPC, 5, 1'b0);
      check("ten_cm_led", int'(led), 0);
      measure(10 * CPC - 1, -1, 1'b1);
      check("just_under_ten_led", int'(led), 1);
      measure(25 * CPC + 15, 0, 1'b1);
      check("long_echo_led", int'(led), 0);
      measure(20, 2, 1'b0);
      check("held_boton_led", int'(led), 1);
      measure((MAXC + 1) * CPC + 7, 2, 1'b0);
      check("saturated_led", int'(led), 0);
      measure(20, -4, 1'b0);
      check("early_echo_led", int'(led), 1);
      no_echo();
      check("timeout_led", int'(led), 0);
      measure(50, 0, 1'b0);
      check("after_timeout_led", int'(led), 1);
      reset_mid();
      measure(12 * CPC, 1, 1'b0);
      check("after_reset_led", int'(led), 0);

      keep = 1'b0;
      for (int i = 0; i < 12; i++) begin
         if (!keep) repeat ($urandom_range(0, 4)) @(negedge clk);
         keep = (i == 11) ? 1'b0 : 1'($urandom_range(0, 1));
         measure(int'($urandom_range(10, 700)), int'($urandom_range(0, 24)) - 4, keep);
      end

      repeat (5) @(negedge clk);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
